// File: rtl/kfmmc_sector_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : kfmmc_sector_buffer_if
// Description : Host CPU register-window bus of the KFMMC sector buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface kfmmc_sector_buffer_if;
    logic [2:0] host_address;
    logic [7:0] host_data_in;
    logic       host_write;
    logic       host_read;
    logic [7:0] host_data_out;
    logic       host_interrupt;

    modport master (
        output host_address,
        output host_data_in,
        output host_write,
        output host_read,
        input  host_data_out,
        input  host_interrupt
    );

    modport slave (
        input  host_address,
        input  host_data_in,
        input  host_write,
        input  host_read,
        output host_data_out,
        output host_interrupt
    );
endinterface
`default_nettype wire

// File: rtl/kfmmc_sector_buffer.sv
`default_nettype none
// ============================================================================
// Module      : kfmmc_sector_buffer
// Description : One-block host buffer in front of the KFMMC drive engine.
//               Optional host interrupt: KFMMC_SECTOR_BUFFER_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module kfmmc_sector_buffer #(
    parameter int         BLOCK_SIZE = 512,
    parameter int         PTR_WIDTH  = 9,
    parameter logic [7:0] CMD_READ   = 8'h01,
    parameter logic [7:0] CMD_WRITE  = 8'h02
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    kfmmc_sector_buffer_if.slave  host,
    output logic [7:0]            data_bus,
    output logic                  write_block_address_1,
    output logic                  write_block_address_2,
    output logic                  write_block_address_3,
    output logic                  write_block_address_4,
    output logic                  write_command,
    output logic                  write_data,
    output logic                  read_data,
    input  wire logic [7:0]       read_data_byte,
    input  wire logic             drive_busy,
    input  wire logic             read_interface_error,
    input  wire logic             write_interface_error,
    input  wire logic             read_byte_interrupt,
    input  wire logic             read_completion_interrupt,
    input  wire logic             request_write_data_interrupt,
    input  wire logic             write_completion_interrupt
);

    localparam logic [2:0] c_st_idle        = 3'd0;
    localparam logic [2:0] c_st_cmd_issue   = 3'd1;
    localparam logic [2:0] c_st_read_fill   = 3'd2;
    localparam logic [2:0] c_st_read_ack    = 3'd3;
    localparam logic [2:0] c_st_write_drain = 3'd4;
    localparam logic [2:0] c_st_write_ack   = 3'd5;
    localparam logic [2:0] c_st_done        = 3'd6;

    localparam logic [PTR_WIDTH:0]   c_block_size = (PTR_WIDTH+1)'(BLOCK_SIZE);
    localparam logic [PTR_WIDTH:0]   c_drv_one    = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] c_host_last  = PTR_WIDTH'(BLOCK_SIZE - 1);
    localparam logic [PTR_WIDTH-1:0] c_host_one   = PTR_WIDTH'(1);

    logic [2:0]           r_state;
    logic                 r_cmd_is_write;
    logic [PTR_WIDTH-1:0] r_host_ptr;
    logic [PTR_WIDTH:0]   r_drv_ptr;
    logic                 r_engine_busy;
    logic                 r_buffer_ready;
    logic                 r_length_error;
    logic [7:0]           r_data_bus;
    logic                 r_wr_ba1;
    logic                 r_wr_ba2;
    logic                 r_wr_ba3;
    logic                 r_wr_ba4;
    logic                 r_wr_cmd;
    logic                 r_wr_data;
    logic                 r_rd_ack;
    logic [7:0]           r_host_data_out;
    logic [7:0]           r_buffer [0:BLOCK_SIZE-1];

    logic                 w_idle;
    logic                 w_wr_data_reg;
    logic                 w_wr_cmd_reg;
    logic                 w_wr_addr_reg;
    logic                 w_rd_data_reg;
    logic                 w_rd_status_reg;
    logic                 w_drv_in_range;
    logic                 w_drive_strobe;
    logic                 w_is_xfer_cmd;
    logic [PTR_WIDTH-1:0] w_host_ptr_next;
    logic [PTR_WIDTH-1:0] w_ram_addr;
    logic                 w_ram_we;
    logic [7:0]           w_ram_wdata;
    logic [7:0]           w_ram_rdata;
    logic [7:0]           w_status;

    assign w_idle          = (r_state == c_st_idle);
    assign w_wr_data_reg   = host.host_write && (host.host_address == 3'd0);
    assign w_wr_cmd_reg    = host.host_write && (host.host_address == 3'd1);
    assign w_wr_addr_reg   = host.host_write && (host.host_address >= 3'd2)
                                             && (host.host_address <= 3'd5);
    assign w_rd_data_reg   = host.host_read  && (host.host_address == 3'd0);
    assign w_rd_status_reg = host.host_read  && (host.host_address == 3'd6);
    assign w_drv_in_range  = (r_drv_ptr < c_block_size);
    assign w_is_xfer_cmd   = (host.host_data_in == CMD_READ) || (host.host_data_in == CMD_WRITE);
    assign w_host_ptr_next = (r_host_ptr == c_host_last) ? '0 : r_host_ptr + c_host_one;

    // Cycles where the FSM itself issues a drive strobe; host address writes yield to these.
    assign w_drive_strobe = ((r_state == c_st_read_fill)
                             && (read_byte_interrupt || read_completion_interrupt))
                         || ((r_state == c_st_write_drain)
                             && (request_write_data_interrupt || write_completion_interrupt));

    // Single RAM port: host owns it in IDLE, drive side owns it everywhere else.
    assign w_ram_addr  = w_idle ? r_host_ptr : r_drv_ptr[PTR_WIDTH-1:0];
    assign w_ram_we    = (w_idle && w_wr_data_reg)
                      || ((r_state == c_st_read_fill) && read_byte_interrupt && w_drv_in_range);
    assign w_ram_wdata = w_idle ? host.host_data_in : read_data_byte;
    assign w_ram_rdata = r_buffer[w_ram_addr];

    assign w_status = {r_engine_busy, r_buffer_ready, r_length_error, write_interface_error,
                       read_interface_error, drive_busy, 2'b00};

    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_buffer[w_ram_addr] <= w_ram_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_st_idle;
            r_cmd_is_write  <= 1'b0;
            r_host_ptr      <= '0;
            r_drv_ptr       <= '0;
            r_engine_busy   <= 1'b0;
            r_buffer_ready  <= 1'b0;
            r_length_error  <= 1'b0;
            r_data_bus      <= 8'h00;
            r_wr_ba1        <= 1'b0;
            r_wr_ba2        <= 1'b0;
            r_wr_ba3        <= 1'b0;
            r_wr_ba4        <= 1'b0;
            r_wr_cmd        <= 1'b0;
            r_wr_data       <= 1'b0;
            r_rd_ack        <= 1'b0;
            r_host_data_out <= 8'h00;
        end else begin
            r_wr_ba1  <= 1'b0;
            r_wr_ba2  <= 1'b0;
            r_wr_ba3  <= 1'b0;
            r_wr_ba4  <= 1'b0;
            r_wr_cmd  <= 1'b0;
            r_wr_data <= 1'b0;
            r_rd_ack  <= 1'b0;

            if (w_wr_addr_reg && !w_drive_strobe) begin
                r_data_bus <= host.host_data_in;
                case (host.host_address)
                    3'd2:    r_wr_ba1 <= 1'b1;
                    3'd3:    r_wr_ba2 <= 1'b1;
                    3'd4:    r_wr_ba3 <= 1'b1;
                    default: r_wr_ba4 <= 1'b1;
                endcase
            end

            if (host.host_read) begin
                case (host.host_address)
                    3'd0:    r_host_data_out <= w_idle ? w_ram_rdata : 8'hFF;
                    3'd6:    r_host_data_out <= w_status;
                    default: r_host_data_out <= 8'h00;
                endcase
            end

            case (r_state)
                c_st_idle: begin
                    if (w_wr_cmd_reg) begin
                        r_data_bus <= host.host_data_in;
                        r_wr_cmd   <= 1'b1;
                        r_host_ptr <= '0;
                        if (w_is_xfer_cmd) begin
                            r_state        <= c_st_cmd_issue;
                            r_cmd_is_write <= (host.host_data_in == CMD_WRITE);
                            r_engine_busy  <= 1'b1;
                            r_drv_ptr      <= '0;
                            r_buffer_ready <= 1'b0;
                            r_length_error <= 1'b0;
                        end
                    end else if (w_wr_data_reg || w_rd_data_reg) begin
                        r_host_ptr <= w_host_ptr_next;
                    end
                end
                c_st_cmd_issue: begin
                    r_state <= r_cmd_is_write ? c_st_write_drain : c_st_read_fill;
                end
                c_st_read_fill: begin
                    // A byte seen together with completion is taken first.
                    if (read_byte_interrupt) begin
                        if (w_drv_in_range) begin
                            r_drv_ptr <= r_drv_ptr + c_drv_one;
                        end else begin
                            r_length_error <= 1'b1;
                        end
                        r_rd_ack <= 1'b1;
                        r_state  <= c_st_read_ack;
                    end else if (read_completion_interrupt) begin
                        if (r_drv_ptr != c_block_size) begin
                            r_length_error <= 1'b1;
                        end
                        r_rd_ack <= 1'b1;
                        r_state  <= c_st_done;
                    end
                end
                c_st_read_ack: begin
                    r_state <= c_st_read_fill;
                end
                c_st_write_drain: begin
                    if (request_write_data_interrupt) begin
                        if (w_drv_in_range) begin
                            r_data_bus <= w_ram_rdata;
                            r_drv_ptr  <= r_drv_ptr + c_drv_one;
                        end else begin
                            r_data_bus     <= 8'hFF;
                            r_length_error <= 1'b1;
                        end
                        r_wr_data <= 1'b1;
                        r_state   <= c_st_write_ack;
                    end else if (write_completion_interrupt) begin
                        r_rd_ack <= 1'b1;
                        r_state  <= c_st_done;
                    end
                end
                c_st_write_ack: begin
                    r_state <= c_st_write_drain;
                end
                c_st_done: begin
                    r_buffer_ready <= 1'b1;
                    r_engine_busy  <= 1'b0;
                    r_host_ptr     <= '0;
                    r_state        <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef KFMMC_SECTOR_BUFFER_IRQ_EN
    logic r_host_irq;
    logic w_enter_done;

    assign w_enter_done = ((r_state == c_st_read_fill) && !read_byte_interrupt
                           && read_completion_interrupt)
                       || ((r_state == c_st_write_drain) && !request_write_data_interrupt
                           && write_completion_interrupt);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_host_irq <= 1'b0;
        end else if (w_rd_status_reg) begin
            r_host_irq <= 1'b0;
        end else if (w_enter_done) begin
            r_host_irq <= 1'b1;
        end
    end

    assign host.host_interrupt = r_host_irq;
`else
    assign host.host_interrupt = 1'b0;
`endif

    assign host.host_data_out    = r_host_data_out;
    assign data_bus              = r_data_bus;
    assign write_block_address_1 = r_wr_ba1;
    assign write_block_address_2 = r_wr_ba2;
    assign write_block_address_3 = r_wr_ba3;
    assign write_block_address_4 = r_wr_ba4;
    assign write_command         = r_wr_cmd;
    assign write_data            = r_wr_data;
    assign read_data             = r_rd_ack;

endmodule
`default_nettype wire

// File: tb/tb_kfmmc_sector_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_kfmmc_sector_buffer
// Description : Scoreboard bench for kfmmc_sector_buffer with a simple drive model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kfmmc_sector_buffer;

    localparam logic [7:0] c_cmd_read  = 8'h01;
    localparam logic [7:0] c_cmd_write = 8'h02;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] data_bus;
    logic       write_block_address_1, write_block_address_2;
    logic       write_block_address_3, write_block_address_4;
    logic       write_command, write_data, read_data;
    logic [7:0] read_data_byte;
    logic       drive_busy, read_interface_error, write_interface_error;
    logic       read_byte_interrupt, read_completion_interrupt;
    logic       request_write_data_interrupt, write_completion_interrupt;

    kfmmc_sector_buffer_if host_bus ();

    kfmmc_sector_buffer dut (
        .clock                        (clock),
        .reset_n                      (reset_n),
        .host                         (host_bus.slave),
        .data_bus                     (data_bus),
        .write_block_address_1        (write_block_address_1),
        .write_block_address_2        (write_block_address_2),
        .write_block_address_3        (write_block_address_3),
        .write_block_address_4        (write_block_address_4),
        .write_command                (write_command),
        .write_data                   (write_data),
        .read_data                    (read_data),
        .read_data_byte               (read_data_byte),
        .drive_busy                   (drive_busy),
        .read_interface_error         (read_interface_error),
        .write_interface_error        (write_interface_error),
        .read_byte_interrupt          (read_byte_interrupt),
        .read_completion_interrupt    (read_completion_interrupt),
        .request_write_data_interrupt (request_write_data_interrupt),
        .write_completion_interrupt   (write_completion_interrupt)
    );

    always #5 clock = ~clock;

    int         n_total = 0;
    int         n_bad   = 0;
    int         ack_cnt = 0;
    int         cmd_cnt = 0;
    int         overlap_cnt = 0;
    logic [7:0] wr_q [$];
    logic [7:0] rd_q [$];
    logic [7:0] model [0:511];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive-side monitor: strobe accounting and drained-byte scoreboard.
    always @(negedge clock) begin
        if ($countones({write_block_address_1, write_block_address_2, write_block_address_3,
                        write_block_address_4, write_command, write_data, read_data}) > 1)
            overlap_cnt++;
        if (read_data)     ack_cnt++;
        if (write_command) cmd_cnt++;
        if (write_data) begin
            if (wr_q.size() == 0) chk("drain_unexpected", 1, 0);
            else                  chk("drain_byte", data_bus, wr_q.pop_front());
        end
    end

    task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clock);
        host_bus.host_address = a;
        host_bus.host_data_in = d;
        host_bus.host_write   = 1'b1;
        @(negedge clock);
        host_bus.host_write   = 1'b0;
    endtask

    task automatic host_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clock);
        host_bus.host_address = a;
        host_bus.host_read    = 1'b1;
        @(negedge clock);
        host_bus.host_read    = 1'b0;
        d = host_bus.host_data_out;
    endtask

    task automatic check_status(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        host_rd(3'd6, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_strobe(input int sel, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = (sel == 0) ? read_data : write_data;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic drive_read_bytes(input int n, input logic [7:0] mask);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            read_data_byte      = 8'(i) ^ mask;
            read_byte_interrupt = 1'b1;
            wait_strobe(0, "rd_byte");
            read_byte_interrupt = 1'b0;
            if (i < 512) model[i] = 8'(i) ^ mask;
        end
    endtask

    task automatic drive_read_done();
        @(negedge clock);
        read_completion_interrupt = 1'b1;
        wait_strobe(0, "rd_done");
        read_completion_interrupt = 1'b0;
    endtask

    task automatic drive_write_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            wr_q.push_back((i < 512) ? model[i] : 8'hFF);
            @(negedge clock);
            request_write_data_interrupt = 1'b1;
            wait_strobe(1, "wr_req");
            request_write_data_interrupt = 1'b0;
        end
    endtask

    task automatic drive_write_done();
        @(negedge clock);
        write_completion_interrupt = 1'b1;
        wait_strobe(0, "wr_done");
        write_completion_interrupt = 1'b0;
    endtask

    task automatic read_back(input int n, input string tag);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(model[i % 512]);
            host_rd(3'd0, d);
            chk(tag, d, rd_q.pop_front());
        end
    endtask

    initial begin
        logic [7:0] d;
        int         c0;
        reset_n = 1'b0;
        host_bus.host_address = 3'd0;
        host_bus.host_data_in = 8'h00;
        host_bus.host_write   = 1'b0;
        host_bus.host_read    = 1'b0;
        read_data_byte = 8'h00;
        {drive_busy, read_interface_error, write_interface_error} = 3'b000;
        {read_byte_interrupt, read_completion_interrupt} = 2'b00;
        {request_write_data_interrupt, write_completion_interrupt} = 2'b00;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        chk("rst_strobes", {write_block_address_1, write_block_address_2, write_block_address_3,
                            write_block_address_4, write_command, write_data, read_data}, 0);
        chk("rst_host_out", host_bus.host_data_out, 8'h00);
        chk("rst_irq", host_bus.host_interrupt, 0);
        check_status("rst_status", 8'h00);

        drive_busy = 1'b1; write_interface_error = 1'b1;
        check_status("status_drv_bits", 8'h14);
        drive_busy = 1'b0; write_interface_error = 1'b0; read_interface_error = 1'b1;
        check_status("status_rie", 8'h08);
        read_interface_error = 1'b0;

        host_wr(3'd3, 8'h12);
        chk("addr_bus", data_bus, 8'h12);
        chk("addr_strobes", {write_block_address_1, write_block_address_2, write_block_address_3,
                             write_block_address_4, write_command}, 5'b01000);
        @(negedge clock);
        chk("addr_strobe_len", write_block_address_2, 0);

        for (int i = 0; i < 512; i++) begin
            model[i] = 8'hA5 ^ 8'(i);
            host_wr(3'd0, model[i]);
        end
        ack_cnt = 0;
        host_wr(3'd1, c_cmd_write);
        chk("wcmd_strobe", write_command, 1);
        chk("wcmd_bus", data_bus, c_cmd_write);
        drive_write_bytes(512);
        drive_write_done();
`ifdef KFMMC_SECTOR_BUFFER_IRQ_EN
        @(negedge clock);
        chk("irq_set", host_bus.host_interrupt, 1);
        check_status("wr_status", 8'h40);
        chk("irq_clear", host_bus.host_interrupt, 0);
`else
        chk("irq_tied", host_bus.host_interrupt, 0);
        check_status("wr_status", 8'h40);
`endif
        chk("wr_acks", ack_cnt, 1);
        chk("wr_q_left", wr_q.size(), 0);

        ack_cnt = 0;
        host_wr(3'd1, c_cmd_read);
        drive_read_bytes(512, 8'h00);
        drive_read_done();
        check_status("rd_status", 8'h40);
        chk("rd_acks", ack_cnt, 513);
        read_back(513, "rd_data");

        host_wr(3'd1, c_cmd_read);
        drive_read_bytes(100, 8'hFF);
        drive_read_done();
        check_status("short_rd_status", 8'h60);

        host_wr(3'd1, c_cmd_write);
        drive_write_bytes(513);
        drive_write_done();
        check_status("long_wr_status", 8'h60);
        chk("long_wr_q_left", wr_q.size(), 0);

        host_wr(3'd1, c_cmd_read);
        drive_read_bytes(5, 8'hC0);
        c0 = cmd_cnt;
        host_wr(3'd1, c_cmd_write);
        host_wr(3'd0, 8'h77);
        repeat (3) @(negedge clock);
        chk("busy_no_cmd", cmd_cnt, c0);
        host_rd(3'd0, d);
        chk("busy_data_ff", d, 8'hFF);
        check_status("busy_status", 8'h80);

        @(negedge clock);
        reset_n = 1'b0;
        read_byte_interrupt = 1'b1;
        repeat (2) @(negedge clock);
        chk("midrst_strobes", {write_block_address_1, write_block_address_2, write_block_address_3,
                               write_block_address_4, write_command, write_data, read_data}, 0);
        read_byte_interrupt = 1'b0;
        reset_n = 1'b1;
        c0 = ack_cnt;
        check_status("midrst_status", 8'h00);
        read_back(6, "midrst_data");
        chk("midrst_no_ack", ack_cnt, c0);
        chk("strobe_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
